ex_mem_skid: RTL and testbench

Execute-to-memory pipeline stage that sits directly downstream of the ALU. It captures each ALU result together with its control payload and presents it to the memory stage through a valid/ready handshake. A two-entry skid buffer keeps `ex_ready` purely registered, so memory-side stalls never form a combinational path back into execute. It also resolves branches and jumps from the ALU result and issues the PC redirect.

---
 rtl/ex_mem_skid_pkg.sv | 27 ++
 rtl/branch_resolve.sv | 26 ++
 rtl/ex_mem_skid.sv | 155 +++++++++++++++
 tb/tb_ex_mem_skid.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_skid_pkg.sv
// Shared encodings and sizing for the execute-to-memory skid stage.
// Holds the dm_type codes, the stage state type and the packed entry width helper.
package ex_mem_skid_pkg;

  typedef enum logic [2:0] {
    DmWord  = 3'd0,
    DmHalf  = 3'd1,
    DmHalfU = 3'd2,
    DmByte  = 3'd3,
    DmByteU = 3'd4
  } dm_type_e;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } skid_state_e;

  // rd(5) + reg_we + mem_we + mem_re + dm_type(3)
  localparam int unsigned EXMEM_CTRL_W = 11;

  // result, addr and wdata are each XLEN wide
  function automatic int unsigned exmem_payload_w(int unsigned xlen);
    return 3 * xlen + EXMEM_CTRL_W;
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution from the ALU result.
// Compiled only when EX_BRANCH_RESOLVE_EN is defined.
`ifdef EX_BRANCH_RESOLVE_EN
module branch_resolve #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] alu_c_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o
);

  logic taken;

  // Branch compare encodings yield zero when the branch is taken
  always_comb begin
    taken      = is_branch_i & (alu_c_i == '0);
    redirect_o = taken | is_jal_i | is_jalr_i;
    target_o   = is_jalr_i ? (alu_c_i & ~XLEN'(1)) : br_target_i;
  end

endmodule
`endif

// File: rtl/ex_mem_skid.sv
// Execute-to-memory stage with a two-entry skid buffer and registered ex_ready.
// Define EX_BRANCH_RESOLVE_EN to add branch/jump resolution and the redirect ports.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_c,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_we,
  input  logic            ex_mem_we,
  input  logic            ex_mem_re,
  input  logic [2:0]      ex_dm_type,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_we,
  output logic            mem_mem_we,
  output logic            mem_mem_re,
  output logic [2:0]      mem_dm_type
`ifdef EX_BRANCH_RESOLVE_EN
  ,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`endif
);

  localparam int unsigned EXMEM_PAYLOAD_W = exmem_payload_w(XLEN);

  skid_state_e                state_q, state_d;
  logic [EXMEM_PAYLOAD_W-1:0] out_q, out_d;
  logic [EXMEM_PAYLOAD_W-1:0] skid_q, skid_d;
  logic [EXMEM_PAYLOAD_W-1:0] in_pl;
  logic                       ex_ready_q, ex_ready_d;
  logic                       accept, rel;
  logic [XLEN-1:0]            result;

  assign accept = ex_valid & ex_ready_q & ~flush;
  assign rel    = mem_valid & mem_ready;
  assign result = (ex_is_jal | ex_is_jalr) ? ex_pc + XLEN'(4) : ex_alu_c;
  assign in_pl  = {result, ex_alu_c, ex_rs2_data, ex_rd, ex_reg_we, ex_mem_we, ex_mem_re,
                   ex_dm_type};

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            out_d   = in_pl;
          end
        end
        StOne: begin
          if (accept && rel) begin
            out_d = in_pl;
          end else if (accept) begin
            skid_d  = in_pl;
            state_d = StFull;
          end else if (rel) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (rel) begin
            out_d   = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    // Ready is a flop so downstream stalls never reach execute combinationally
    ex_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StEmpty;
      out_q      <= '0;
      skid_q     <= '0;
      ex_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      ex_ready_q <= ex_ready_d;
    end
  end

  assign ex_ready  = ex_ready_q;
  assign mem_valid = (state_q != StEmpty);
  assign {mem_result, mem_addr, mem_wdata, mem_rd, mem_reg_we, mem_mem_we, mem_mem_re,
          mem_dm_type} = out_q;

`ifdef EX_BRANCH_RESOLVE_EN
  logic            br_redirect;
  logic [XLEN-1:0] br_target;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  branch_resolve #(
    .XLEN (XLEN)
  ) u_branch_resolve (
    .alu_c_i     (ex_alu_c),
    .br_target_i (ex_br_target),
    .is_branch_i (ex_is_branch),
    .is_jal_i    (ex_is_jal),
    .is_jalr_i   (ex_is_jalr),
    .redirect_o  (br_redirect),
    .target_o    (br_target)
  );

  always_comb begin
    redirect_valid_d = accept & br_redirect;
    redirect_pc_d    = redirect_valid_d ? br_target : redirect_pc_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
`else
  // Control-flow decision lives elsewhere in this build
  logic unused_is_branch;
  assign unused_is_branch = ex_is_branch;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Self-checking bench for ex_mem_skid: directed scenarios plus randomized traffic
// checked against a queue-based model of the held entries.
module tb_ex_mem_skid;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn, flush, ex_valid, ex_ready, mem_valid, mem_ready;
  logic [XLEN-1:0] ex_alu_c, ex_rs2_data, ex_pc, ex_br_target;
  logic [4:0]      ex_rd, mem_rd;
  logic            ex_reg_we, ex_mem_we, ex_mem_re;
  logic [2:0]      ex_dm_type, mem_dm_type;
  logic            ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [XLEN-1:0] mem_result, mem_addr, mem_wdata;
  logic            mem_reg_we, mem_mem_we, mem_mem_re;
`ifdef EX_BRANCH_RESOLVE_EN
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            exp_rv;
  logic [XLEN-1:0] exp_rpc;
`endif

  always #5 clk = ~clk;

  ex_mem_skid #(
    .XLEN (XLEN)
  ) dut (
`ifdef EX_BRANCH_RESOLVE_EN
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`endif
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_alu_c     (ex_alu_c),
    .ex_rs2_data  (ex_rs2_data),
    .ex_pc        (ex_pc),
    .ex_br_target (ex_br_target),
    .ex_rd        (ex_rd),
    .ex_reg_we    (ex_reg_we),
    .ex_mem_we    (ex_mem_we),
    .ex_mem_re    (ex_mem_re),
    .ex_dm_type   (ex_dm_type),
    .ex_is_branch (ex_is_branch),
    .ex_is_jal    (ex_is_jal),
    .ex_is_jalr   (ex_is_jalr),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_result   (mem_result),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_reg_we   (mem_reg_we),
    .mem_mem_we   (mem_mem_we),
    .mem_mem_re   (mem_mem_re),
    .mem_dm_type  (mem_dm_type)
  );

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_we;
    logic            mem_re;
    logic [2:0]      dm;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic ent_t entry_of_inputs();
    ent_t e;
    e.result = (ex_is_jal || ex_is_jalr) ? ex_pc + 32'd4 : ex_alu_c;
    e.addr   = ex_alu_c;
    e.wdata  = ex_rs2_data;
    e.rd     = ex_rd;
    e.reg_we = ex_reg_we;
    e.mem_we = ex_mem_we;
    e.mem_re = ex_mem_re;
    e.dm     = ex_dm_type;
    return e;
  endfunction

  // Advance one clock, updating the model from the inputs applied for this edge
  task automatic tick();
    bit   rdy, rel, acc;
    ent_t e;
    rdy = (q.size() < 2);
    rel = (q.size() > 0) && (mem_ready === 1'b1);
    acc = (ex_valid === 1'b1) && rdy && (flush !== 1'b1);
    e   = entry_of_inputs();
`ifdef EX_BRANCH_RESOLVE_EN
    exp_rv = acc && (ex_is_jal || ex_is_jalr || (ex_is_branch && ex_alu_c == 0));
    if (exp_rv) exp_rpc = ex_is_jalr ? {ex_alu_c[XLEN-1:1], 1'b0} : ex_br_target;
`endif
    if (rel) void'(q.pop_front());
    if (flush === 1'b1) q.delete();
    else if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    ex_valid     = 1'b0;
    flush        = 1'b0;
    ex_is_branch = 1'b0;
    ex_is_jal    = 1'b0;
    ex_is_jalr   = 1'b0;
  endtask

  // cls: 0 plain ALU op, 1 branch, 2 jal, 3 jalr
  task automatic present(input logic [XLEN-1:0] c, input logic [XLEN-1:0] pc, input int cls,
                         input logic [XLEN-1:0] tgt);
    ex_valid     = 1'b1;
    ex_alu_c     = c;
    ex_pc        = pc;
    ex_br_target = tgt;
    ex_is_branch = (cls == 1);
    ex_is_jal    = (cls == 2);
    ex_is_jalr   = (cls == 3);
    ex_rs2_data  = $urandom;
    ex_rd        = 5'($urandom);
    ex_reg_we    = 1'($urandom);
    ex_mem_we    = 1'($urandom);
    ex_mem_re    = 1'($urandom);
    ex_dm_type   = 3'($urandom_range(0, 4));
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    mem_ready = 1'b0;
    present(32'h1234, 32'h10, 0, 32'h0);
    repeat (3) @(negedge clk);
    idle();
    rstn = 1'b1;
    q.delete();
    checks++; if (mem_valid !== 1'b0) begin errors++;
      $display("FAIL reset_mem_valid got=%b want=0", mem_valid); end
    checks++; if (ex_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ex_ready got=%b want=1", ex_ready); end
    checks++; if ({mem_result, mem_addr, mem_wdata} !== '0) begin errors++;
      $display("FAIL reset_payload got=%h %h %h want=0", mem_result, mem_addr, mem_wdata); end
    checks++;
    if ({mem_rd, mem_reg_we, mem_mem_we, mem_mem_re, mem_dm_type} !== 11'd0) begin errors++;
      $display("FAIL reset_ctrl got=%h want=0",
               {mem_rd, mem_reg_we, mem_mem_we, mem_mem_re, mem_dm_type}); end
`ifdef EX_BRANCH_RESOLVE_EN
    checks++; if (redirect_valid !== 1'b0 || redirect_pc !== '0) begin errors++;
      $display("FAIL reset_redirect got=%b/%h want=0/0", redirect_valid, redirect_pc); end
`endif
    tick();
    checks++; if (ex_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready_after got=%b want=1", ex_ready); end
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] cs[8];
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cs[i] = $urandom;
      present(cs[i], 32'h100 + 32'(4 * i), 0, 32'h0);
      tick();
      checks++; if (mem_valid !== 1'b1 || mem_result !== cs[i]) begin errors++;
        $display("FAIL stream_%0d got=%b/%h want=1/%h", i, mem_valid, mem_result, cs[i]); end
      checks++; if (ex_ready !== 1'b1) begin errors++;
        $display("FAIL stream_ready_%0d got=%b want=1", i, ex_ready); end
    end
    idle();
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++;
      $display("FAIL stream_drain got=%b want=0", mem_valid); end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    mem_ready = 1'b0;
    present(a, 32'h200, 0, 32'h0);
    tick();
    checks++; if (mem_result !== a || ex_ready !== 1'b1) begin errors++;
      $display("FAIL bp_a got=%h/%b want=%h/1", mem_result, ex_ready, a); end
    present(b, 32'h204, 0, 32'h0);
    tick();
    checks++; if (mem_result !== a || ex_ready !== 1'b0) begin errors++;
      $display("FAIL bp_full got=%h/%b want=%h/0", mem_result, ex_ready, a); end
    present(c, 32'h208, 0, 32'h0);
    tick();
    checks++; if (mem_result !== a || ex_ready !== 1'b0 || mem_valid !== 1'b1) begin errors++;
      $display("FAIL bp_hold got=%h/%b want=%h/0", mem_result, ex_ready, a); end
    mem_ready = 1'b1;
    tick();
    checks++; if (mem_result !== b || ex_ready !== 1'b1) begin errors++;
      $display("FAIL bp_b got=%h/%b want=%h/1", mem_result, ex_ready, b); end
    tick();
    checks++; if (mem_result !== c || mem_valid !== 1'b1) begin errors++;
      $display("FAIL bp_c got=%h/%b want=%h/1", mem_result, mem_valid, c); end
    idle();
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++;
      $display("FAIL bp_no_dup got=%b want=0", mem_valid); end
  endtask

  task automatic test_flush_full();
    mem_ready = 1'b0;
    present($urandom, 32'h300, 0, 32'h0);
    tick();
    present($urandom, 32'h304, 0, 32'h0);
    tick();
    checks++; if (ex_ready !== 1'b0) begin errors++;
      $display("FAIL flush_setup got=%b want=0", ex_ready); end
    present($urandom, 32'h308, 0, 32'h0);
    flush = 1'b1;
    tick();
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1) begin errors++;
      $display("FAIL flush_empty got=%b/%b want=0/1", mem_valid, ex_ready); end
    idle();
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++;
      $display("FAIL flush_not_captured got=%b want=0", mem_valid); end
  endtask

  task automatic test_jalr();
    mem_ready = 1'b1;
    present(32'h203, 32'h40, 3, 32'h999);
    tick();
    checks++; if (mem_result !== 32'h44 || mem_addr !== 32'h203) begin errors++;
      $display("FAIL jalr_result got=%h/%h want=44/203", mem_result, mem_addr); end
`ifdef EX_BRANCH_RESOLVE_EN
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h202) begin errors++;
      $display("FAIL jalr_redirect got=%b/%h want=1/202", redirect_valid, redirect_pc); end
`endif
    idle();
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++;
      $display("FAIL jalr_drain got=%b want=0", mem_valid); end
  endtask

`ifdef EX_BRANCH_RESOLVE_EN
  task automatic test_redirect();
    mem_ready = 1'b1;
    present(32'h0, 32'h80, 1, 32'h100);
    tick();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++;
      $display("FAIL bne_taken got=%b/%h want=1/100", redirect_valid, redirect_pc); end
    idle();
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++;
      $display("FAIL bne_one_pulse got=%b want=0", redirect_valid); end
    present(32'h1, 32'h80, 1, 32'h100);
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++;
      $display("FAIL bne_not_taken got=%b want=0", redirect_valid); end
    present(32'h5, 32'h90, 2, 32'h180);
    flush = 1'b1;
    tick();
    checks++; if (redirect_valid !== 1'b0) begin errors++;
      $display("FAIL jal_flushed got=%b want=0", redirect_valid); end
    idle();
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    present($urandom, 32'h400, 0, 32'h0);
    tick();
    present($urandom, 32'h404, 0, 32'h0);
    tick();
    #2 rstn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || ex_ready !== 1'b1 || mem_result !== '0) begin errors++;
      $display("FAIL mid_reset got=%b/%b/%h want=0/1/0", mem_valid, ex_ready, mem_result); end
    q.delete();
    idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    checks++; if (ex_ready !== 1'b1 || mem_valid !== 1'b0) begin errors++;
      $display("FAIL mid_reset_after got=%b/%b want=1/0", ex_ready, mem_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        present(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, $urandom,
                int'($urandom_range(0, 3)), $urandom);
      end else begin
        idle();
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 30) == 0);
      tick();
      checks++; if (ex_ready !== (q.size() < 2)) begin errors++;
        $display("FAIL rnd_ready_%0d got=%b want=%b", i, ex_ready, q.size() < 2); end
      checks++; if (mem_valid !== (q.size() > 0)) begin errors++;
        $display("FAIL rnd_valid_%0d got=%b want=%b", i, mem_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++;
        if ({mem_result, mem_addr, mem_wdata, mem_rd, mem_reg_we, mem_mem_we, mem_mem_re,
             mem_dm_type} !== q[0]) begin
          errors++;
          $display("FAIL rnd_payload_%0d got=%h/%h/%h want=%h/%h/%h", i, mem_result, mem_addr,
                   mem_wdata, q[0].result, q[0].addr, q[0].wdata);
        end
      end
`ifdef EX_BRANCH_RESOLVE_EN
      checks++; if (redirect_valid !== exp_rv) begin errors++;
        $display("FAIL rnd_redir_%0d got=%b want=%b", i, redirect_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (redirect_pc !== exp_rpc) begin errors++;
          $display("FAIL rnd_rpc_%0d got=%h want=%h", i, redirect_pc, exp_rpc); end
      end
`endif
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_jalr();
`ifdef EX_BRANCH_RESOLVE_EN
    test_redirect();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
